// File: rtl/hbm_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_axi_pkg
//  Description : Shared AXI4 constants, write-engine state type and helpers
//                for the HBM write port.
//  Revision    : 1.0 - initial release
// ============================================================================
package hbm_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_t;

    // AXI AxSIZE encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hbm_write_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_write_port_if
//  Description : Control, write-stream and AXI4 write-channel bundle for one
//                HBM write port. "master" is the write engine side, "slave"
//                is the stream source / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hbm_write_port_if #(
    parameter int ID_WIDTH   = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    // transfer control
    logic                    start;
    logic                    done;
    logic                    error;
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [ADDR_WIDTH-1:0]   end_addr;
    // write data stream
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    data_valid;
    logic                    data_ready;
    // AW channel
    logic [ID_WIDTH-1:0]     m_axi_awid;
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [7:0]              m_axi_awlen;
    logic [2:0]              m_axi_awsize;
    logic [1:0]              m_axi_awburst;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    // W channel
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wlast;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    // B channel
    logic [ID_WIDTH-1:0]     m_axi_bid;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport master (
        input  start, start_addr, end_addr, data_in, data_valid,
        input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output done, error, data_ready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_bready
    );

    modport slave (
        output start, start_addr, end_addr, data_in, data_valid,
        output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  done, error, data_ready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_bready
    );

endinterface
`default_nettype wire

// File: rtl/hbm_wr_burst_calc.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_wr_burst_calc
//  Description : Combinational burst sizing. Given the current and the
//                exclusive end byte address, returns the beat count of the
//                next burst (whole beats only, capped at BURST_LEN), its
//                AWLEN, whether it finishes the range, and whether nothing
//                is left to write.
//  Revision    : 1.0 - initial release
// ============================================================================
module hbm_wr_burst_calc #(
    parameter int BURST_LEN  = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  wire logic [ADDR_WIDTH-1:0] cur_addr_i,
    input  wire logic [ADDR_WIDTH-1:0] end_addr_i,
    output logic      [8:0]            beats_o,
    output logic      [7:0]            awlen_o,
    output logic                       last_burst_o,
    output logic                       empty_o
);

    localparam int c_bytes = DATA_WIDTH / 8;
    localparam int c_shift = $clog2(c_bytes);

    logic [ADDR_WIDTH-1:0] w_remaining;
    logic [ADDR_WIDTH-1:0] w_words;

    // Whole beats left in the range; a trailing partial beat is dropped.
    always_comb begin
        w_remaining  = end_addr_i - cur_addr_i;
        w_words      = w_remaining >> c_shift;
        // cur >= end also catches a cur_addr that wrapped past end_addr.
        empty_o      = (cur_addr_i >= end_addr_i) ||
                       (w_remaining < ADDR_WIDTH'(c_bytes));
        last_burst_o = (w_words <= ADDR_WIDTH'(BURST_LEN));
        if (empty_o) begin
            beats_o = 9'd0;
        end else if (w_words >= ADDR_WIDTH'(BURST_LEN)) begin
            beats_o = 9'(BURST_LEN);
        end else begin
            beats_o = w_words[8:0];
        end
        awlen_o = 8'(beats_o - 9'd1);
    end

endmodule
`default_nettype wire

// File: rtl/hbm_write_port.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_write_port
//  Description : Single-port AXI4 write master. Drains a valid/ready stream
//                into HBM as INCR bursts over [start_addr, end_addr), one
//                outstanding burst at a time (AW -> W -> B).
//                Optional build macro HBM_WRITE_PERF_EN adds saturating
//                beat_count / stall_cycles performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hbm_write_port
    import hbm_axi_pkg::*;
#(
    parameter int BURST_LEN  = 64,
    parameter int ID_WIDTH   = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  wire logic         clk,
    input  wire logic         nrst,
    hbm_write_port_if.master  bus
`ifdef HBM_WRITE_PERF_EN
    ,
    output logic [31:0]       beat_count,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int         c_bytes  = DATA_WIDTH / 8;
    localparam int         c_shift  = $clog2(c_bytes);
    localparam logic [2:0] c_awsize = axi_size(c_bytes);

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic [8:0]            beats_q, beats_d;
    logic                  last_q, last_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] w_calc_addr;
    logic [8:0]            w_calc_beats;
    logic [7:0]            w_calc_awlen;
    logic                  w_calc_last;
    logic                  w_calc_empty;
    logic                  w_awvalid;
    logic                  w_wvalid;
    logic                  w_data_ready;
    logic                  w_bready;
    logic                  w_wfire;

    // In IDLE the range check must look at start_addr before it is latched.
    assign w_calc_addr = (state_q == ST_IDLE) ? bus.start_addr : cur_addr_q;

    hbm_wr_burst_calc #(
        .BURST_LEN  (BURST_LEN),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_calc (
        .cur_addr_i   (w_calc_addr),
        .end_addr_i   (bus.end_addr),
        .beats_o      (w_calc_beats),
        .awlen_o      (w_calc_awlen),
        .last_burst_o (w_calc_last),
        .empty_o      (w_calc_empty)
    );

    // Next-state and channel-control decode for the AW -> W -> B sequence.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beat_cnt_d   = beat_cnt_q;
        beats_d      = beats_q;
        last_d       = last_q;
        error_d      = error_q;
        done_d       = 1'b0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_data_ready = 1'b0;
        w_bready     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cur_addr_d = bus.start_addr;
                    error_d    = 1'b0;
                    if (w_calc_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_AW;
                    end
                end
            end
            ST_AW: begin
                w_awvalid = 1'b1;
                if (bus.m_axi_awready) begin
                    beat_cnt_d = w_calc_beats;
                    beats_d    = w_calc_beats;
                    last_d     = w_calc_last;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                w_wvalid     = bus.data_valid;
                w_data_ready = bus.m_axi_wready;
                if (bus.data_valid && bus.m_axi_wready) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    if (beat_cnt_q == 9'd1) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                w_bready = 1'b1;
                if (bus.m_axi_bvalid) begin
                    if (bus.m_axi_bresp != AXI_RESP_OKAY) begin
                        error_d = 1'b1;
                    end
                    cur_addr_d = cur_addr_q + (ADDR_WIDTH'(beats_q) << c_shift);
                    if (last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_AW;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight burst.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            beat_cnt_q <= '0;
            beats_q    <= '0;
            last_q     <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            beat_cnt_q <= beat_cnt_d;
            beats_q    <= beats_d;
            last_q     <= last_d;
            error_q    <= error_d;
            done_q     <= done_d;
        end
    end

    assign w_wfire = (state_q == ST_W) && bus.data_valid && bus.m_axi_wready;

    // Address/length/data are forced to zero outside their active state so
    // the bus is quiet while idle or in reset.
    assign bus.m_axi_awid    = '0;
    assign bus.m_axi_awaddr  = (state_q == ST_AW) ? cur_addr_q : '0;
    assign bus.m_axi_awlen   = (state_q == ST_AW) ? w_calc_awlen : 8'd0;
    assign bus.m_axi_awsize  = c_awsize;
    assign bus.m_axi_awburst = AXI_BURST_INCR;
    assign bus.m_axi_awvalid = w_awvalid;
    assign bus.m_axi_wdata   = (state_q == ST_W) ? bus.data_in : '0;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wlast   = (state_q == ST_W) && (beat_cnt_q == 9'd1);
    assign bus.m_axi_wvalid  = w_wvalid;
    assign bus.m_axi_bready  = w_bready;
    assign bus.data_ready    = w_data_ready;
    assign bus.done          = done_q;
    assign bus.error         = error_q;

    // Response ID is deliberately ignored: only one burst is ever in flight.
    logic w_unused;
    assign w_unused = &{1'b0, bus.m_axi_bid};

`ifdef HBM_WRITE_PERF_EN
    logic [31:0] beat_count_q;
    logic [31:0] stall_cycles_q;

    // Accepted W beats, saturating; cleared when a new transfer starts.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            beat_count_q <= '0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            beat_count_q <= '0;
        end else if (w_wfire && (beat_count_q != '1)) begin
            beat_count_q <= beat_count_q + 32'd1;
        end
    end

    // Cycles where data was offered but the memory held wready low.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cycles_q <= '0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            stall_cycles_q <= '0;
        end else if ((state_q == ST_W) && bus.data_valid && !bus.m_axi_wready &&
                     (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign beat_count   = beat_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hbm_write_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hbm_write_port
//  Description : Directed, table-driven bench for hbm_write_port
//                (DATA_WIDTH=256, BURST_LEN=64) acting as stream source and
//                AXI write slave. Build with HBM_WRITE_PERF_EN to also check
//                the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hbm_write_port;

    localparam int DW = 256;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int BL = 64;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    hbm_write_port_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef HBM_WRITE_PERF_EN
    logic [31:0] beat_count;
    logic [31:0] stall_cycles;
`endif

    hbm_write_port #(
        .BURST_LEN  (BL),
        .ID_WIDTH   (IW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
`ifdef HBM_WRITE_PERF_EN
        ,
        .beat_count   (beat_count),
        .stall_cycles (stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] pat(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 + k;
        return {w, ~w, w ^ 32'h5A5A_5A5A, w, ~w, w + 32'd7, w, w ^ 32'hFFFF_0000};
    endfunction

    // Beats of the next burst from the range definition (32 B per beat).
    function automatic int model_beats(input logic [31:0] cur, input logic [31:0] ea);
        logic [31:0] rem;
        if (cur >= ea) return 0;
        rem = ea - cur;
        if (rem < 32'd32) return 0;
        if ((rem >> 5) > 32'(BL)) return BL;
        return int'(rem >> 5);
    endfunction

    typedef struct {
        logic [31:0] sa;
        logic [31:0] ea;
        int          gap;
        bit          err1;
        int          n_aw;
        int          beats;
        logic [31:0] aw0;
        int          len_last;
        bit          err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic quiet_inputs();
        bus.start         = 1'b0;
        bus.data_valid    = 1'b0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
    endtask

    task automatic do_transfer(input logic [31:0] sa, input logic [31:0] ea, input int gap,
                               input bit err_first, output int n_aw, output int beats,
                               output logic [31:0] first_aw, output int last_len,
                               output logic err_end);
        logic [31:0] exp_addr;
        int exp_len, beat_idx, burst_beat, n_b, done_cnt, done_due, err_chk_cyc, stalls;
        bit in_burst, b_pend, b_acc, dv_hold, finished;
        n_aw = 0; beats = 0; first_aw = '1; last_len = -1; err_end = 1'b0;
        exp_addr = sa; exp_len = model_beats(sa, ea);
        beat_idx = 0; burst_beat = 0; n_b = 0; done_cnt = 0; stalls = 0;
        done_due = -1; err_chk_cyc = -1;
        in_burst = 0; b_pend = 0; b_acc = 0; dv_hold = 0; finished = 0;

        @(negedge clk);
        quiet_inputs();
        bus.start_addr = sa;
        bus.end_addr   = ea;
        bus.start      = 1'b1;
        if (exp_len == 0) done_due = 1;

        for (int cyc = 1; cyc <= 20000 && !finished; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (b_acc) begin
                bus.m_axi_bvalid = 1'b0;
                b_acc = 0;
            end
            if (cyc == 1) check("error_cleared_on_start", bus.error, 1'b0);
            if (cyc == err_chk_cyc) check("error_after_b", bus.error, err_first);
            check("awvalid_state", bus.m_axi_awvalid, !in_burst && !b_pend && exp_len != 0);
            check("bready_state", bus.m_axi_bready, b_pend);
            if (bus.done) begin
                done_cnt++;
                check("done_timing", cyc, done_due);
                err_end  = bus.error;
                finished = 1;
            end
            if (!finished) begin
                bus.m_axi_awready = ($urandom_range(99) >= gap);
                bus.m_axi_wready  = ($urandom_range(99) >= gap);
                if (!dv_hold) bus.data_valid = ($urandom_range(99) >= gap);
                bus.data_in = pat(beat_idx);
                if (b_pend && !bus.m_axi_bvalid) bus.m_axi_bvalid = ($urandom_range(99) >= gap);
                bus.m_axi_bresp = (err_first && n_b == 0) ? 2'b10 : 2'b00;
                bus.m_axi_bid   = 32'h0000_0005;
                #1;
                if (in_burst) begin
                    check("wvalid_passthru", bus.m_axi_wvalid, bus.data_valid);
                    check("data_ready_is_wready", bus.data_ready, bus.m_axi_wready);
                    if (bus.data_valid && !bus.m_axi_wready) stalls++;
                end else begin
                    check("w_quiet_outside_W", {bus.m_axi_wvalid, bus.data_ready}, 2'b00);
                end
                dv_hold = bus.data_valid;
                if (in_burst && bus.m_axi_wvalid && bus.m_axi_wready) begin
                    check("wdata", bus.m_axi_wdata, pat(beat_idx));
                    check("wlast", bus.m_axi_wlast, burst_beat == exp_len - 1);
                    beat_idx++; burst_beat++; beats++;
                    dv_hold = 0;
                    if (burst_beat == exp_len) begin
                        in_burst = 0;
                        b_pend   = 1;
                    end
                end
                if (bus.m_axi_awvalid) begin
                    check("awaddr", bus.m_axi_awaddr, exp_addr);
                    check("awlen", bus.m_axi_awlen, 8'(exp_len - 1));
                    if (bus.m_axi_awready) begin
                        check("aw_consts", {bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst},
                              {32'd0, 3'd5, 2'b01});
                        check("wstrb", bus.m_axi_wstrb, {32{1'b1}});
                        n_aw++;
                        if (n_aw == 1) first_aw = bus.m_axi_awaddr;
                        last_len   = int'(bus.m_axi_awlen);
                        in_burst   = 1;
                        burst_beat = 0;
                    end
                end
                if (bus.m_axi_bvalid && bus.m_axi_bready) begin
                    n_b++;
                    b_pend = 0;
                    b_acc  = 1;
                    err_chk_cyc = cyc + 1;
                    exp_addr = exp_addr + 32'(exp_len * 32);
                    exp_len  = model_beats(exp_addr, ea);
                    if (exp_len == 0) done_due = cyc + 1;
                end
            end
        end
        check("done_seen_once", done_cnt, 1);
`ifdef HBM_WRITE_PERF_EN
        check("perf_beat_count", beat_count, beats);
        check("perf_stall_cycles", stall_cycles, stalls);
`endif
        @(negedge clk);
        quiet_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("done_single_pulse", bus.done, 1'b0);
        end
    endtask

    initial begin
        int          n_aw, beats, last_len, n;
        logic [31:0] first_aw;
        logic        err_end;

        vecs[0] = '{32'h0000_0000, 32'h0000_1000,  0, 0, 2, 128, 32'h0000_0000, 63, 0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0A00,  0, 0, 2,  80, 32'h0000_0000, 15, 0};
        vecs[2] = '{32'h0000_1000, 32'h0000_1000,  0, 0, 0,   0, 32'hFFFF_FFFF, -1, 0};
        vecs[3] = '{32'h0000_0000, 32'h0000_1000, 50, 0, 2, 128, 32'h0000_0000, 63, 0};
        vecs[4] = '{32'h0000_4000, 32'h0000_5000,  0, 1, 2, 128, 32'h0000_4000, 63, 1};
        vecs[5] = '{32'h0000_2000, 32'h0000_201F,  0, 0, 0,   0, 32'hFFFF_FFFF, -1, 0};
        vecs[6] = '{32'h0000_3000, 32'h0000_2000,  0, 0, 0,   0, 32'hFFFF_FFFF, -1, 0};
        vecs[7] = '{32'h0000_0800, 32'h0000_1025,  0, 0, 2,  65, 32'h0000_0800,  0, 0};
        vecs[8] = '{32'h0000_0000, 32'h0000_1000, 30, 1, 2, 128, 32'h0000_0000, 63, 1};
        vecs[9] = '{32'hFFFF_F800, 32'hFFFF_FFF0,  0, 0, 1,  63, 32'hFFFF_F800, 62, 0};

        quiet_inputs();
        bus.start_addr = '0;
        bus.end_addr   = '0;
        bus.data_in    = '0;
        bus.m_axi_bid  = '0;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.data_ready,
               bus.done, bus.error, bus.m_axi_wlast},
              7'd0);
        check("reset_aw_fields", {bus.m_axi_awaddr, bus.m_axi_awlen}, 40'd0);
        check("const_awsize_awburst", {bus.m_axi_awsize, bus.m_axi_awburst}, {3'd5, 2'b01});
`ifdef HBM_WRITE_PERF_EN
        check("reset_perf", {beat_count, stall_cycles}, 64'd0);
`endif
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            do_transfer(vecs[i].sa, vecs[i].ea, vecs[i].gap, vecs[i].err1,
                        n_aw, beats, first_aw, last_len, err_end);
            check($sformatf("vec%0d_n_aw", i), n_aw, vecs[i].n_aw);
            check($sformatf("vec%0d_beats", i), beats, vecs[i].beats);
            check($sformatf("vec%0d_first_awaddr", i), first_aw, vecs[i].aw0);
            check($sformatf("vec%0d_last_awlen", i), last_len, vecs[i].len_last);
            check($sformatf("vec%0d_error_at_done", i), err_end, vecs[i].err);
        end

        // Reset in the middle of a burst: everything drops the next cycle.
        @(negedge clk);
        bus.start_addr    = 32'h0;
        bus.end_addr      = 32'h1000;
        bus.start         = 1'b1;
        bus.m_axi_awready = 1'b1;
        bus.m_axi_wready  = 1'b1;
        bus.data_valid    = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.m_axi_wvalid && bus.m_axi_wready) n++;
        end
        check("midreset_beats_before", n, 10);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("midreset_outputs",
              {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.data_ready,
               bus.done, bus.error},
              6'd0);
        nrst = 1'b1;
        quiet_inputs();
        @(negedge clk);
        check("midreset_idle_quiet", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b00);
        do_transfer(32'h0, 32'h1000, 0, 0, n_aw, beats, first_aw, last_len, err_end);
        check("restart_n_aw", n_aw, 2);
        check("restart_first_awaddr", first_aw, 32'h0);
        check("restart_beats", beats, 128);

        // start is ignored while a transfer is running.
        @(negedge clk);
        bus.start_addr    = 32'h0;
        bus.end_addr      = 32'h0040;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start_addr    = 32'h8000;
        check("busy_awaddr", bus.m_axi_awaddr, 32'h0);
        bus.m_axi_awready = 1'b1;
        @(negedge clk);
        bus.m_axi_awready = 1'b0;
        bus.start         = 1'b0;
        check("busy_in_W", bus.m_axi_awvalid, 1'b0);
        bus.data_valid   = 1'b1;
        bus.m_axi_wready = 1'b1;
        repeat (2) @(negedge clk);
        bus.data_valid   = 1'b0;
        bus.m_axi_wready = 1'b0;
        check("busy_in_B", bus.m_axi_bready, 1'b1);
        bus.m_axi_bvalid = 1'b1;
        @(negedge clk);
        bus.m_axi_bvalid = 1'b0;
        check("busy_done", bus.done, 1'b1);
        @(negedge clk);
        check("busy_no_restart", bus.m_axi_awvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
